memstream_strm_fifo: RTL and testbench

- Per-stream output buffer placed directly downstream of each memstream `m_axis_N` port.
- Absorbs the memory read pipeline latency and provides the `m_axis_N_afull` back-pressure input that memstream uses to throttle its read requests.
- Presents a clean, fully registered AXI-Stream master to the consuming compute stage (MVAU weight input).
- One instance per stream; instantiated by the stream wrapper for NSTREAMS > 0.

---
 rtl/memstream_strm_fifo.sv | 118 +++++++++++
 tb/tb_memstream_strm_fifo.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/memstream_strm_fifo.sv
// Per-stream output FIFO for memstream: RAM with synchronous read, a read stage and an output
// register, with registered tready/afull. Define MEMSTREAM_STRM_FIFO_OCCUPANCY_EN to expose the fill level.
module memstream_strm_fifo #(
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned DEPTH        = 32,
    parameter int unsigned AFULL_MARGIN = 4,
    parameter string       RAM_STYLE    = "auto"
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    input  logic [WIDTH-1:0]           s_axis_tdata,
    input  logic                       s_axis_tvalid,
    output logic                       s_axis_tready,
    output logic                       s_axis_afull,
    output logic [WIDTH-1:0]           m_axis_tdata,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic [$clog2(DEPTH):0]     occupancy
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C = CW'(DEPTH - AFULL_MARGIN);

    (* ram_style = RAM_STYLE *) logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    ram_cnt_q, ram_cnt_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             rd_valid_q, out_valid_q;
    logic [WIDTH-1:0] rd_data_q, out_data_q;
    logic             tready_q, afull_q;

    logic push, pop, out_load, rd_issue;

    always_comb begin
        push     = s_axis_tvalid & tready_q;
        pop      = out_valid_q & m_axis_tready;
        // Read stage feeds the output register whenever it is empty or being popped.
        out_load = rd_valid_q & (~out_valid_q | pop);
        rd_issue = (ram_cnt_q != '0) & (~rd_valid_q | out_load);
    end

    always_comb begin
        cnt_d = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_comb begin
        ram_cnt_d = ram_cnt_q;
        case ({push, rd_issue})
            2'b10:   ram_cnt_d = ram_cnt_q + CW'(1);
            2'b01:   ram_cnt_d = ram_cnt_q - CW'(1);
            default: ram_cnt_d = ram_cnt_q;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            ram_cnt_q   <= '0;
            cnt_q       <= '0;
            rd_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            tready_q    <= 1'b0;
            afull_q     <= 1'b0;
        end else begin
            ram_cnt_q <= ram_cnt_d;
            cnt_q     <= cnt_d;
            tready_q  <= (cnt_d < DEPTH_C);
            afull_q   <= (cnt_d >= AFULL_C);
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (rd_issue) begin
                rd_ptr_q   <= rd_ptr_q + AW'(1);
                rd_valid_q <= 1'b1;
            end else if (out_load) begin
                rd_valid_q <= 1'b0;
            end
            if (out_load) begin
                out_data_q  <= rd_data_q;
                out_valid_q <= 1'b1;
            end else if (pop) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    // Storage and its read register stay reset-free so they map onto block RAM.
    always_ff @(posedge aclk) begin
        if (push) begin
            mem[wr_ptr_q] <= s_axis_tdata;
        end
        if (rd_issue) begin
            rd_data_q <= mem[rd_ptr_q];
        end
    end

    assign s_axis_tready = tready_q;
    assign s_axis_afull  = afull_q;
    assign m_axis_tdata  = out_data_q;
    assign m_axis_tvalid = out_valid_q;

`ifdef MEMSTREAM_STRM_FIFO_OCCUPANCY_EN
    assign occupancy = cnt_q;
`else
    assign occupancy = '0;
`endif

endmodule

// File: tb/tb_memstream_strm_fifo.sv
// Bench for memstream_strm_fifo: queue-based reference model compared every cycle, plus
// directed literal checks on latency, almost-full/full thresholds and reset.
module tb_memstream_strm_fifo;

    localparam int D = 32;
    localparam int M = 4;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [31:0] s_tdata = '0;
    logic        s_tvalid = 1'b0;
    logic        s_tready, s_afull;
    logic [31:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready = 1'b0;
    logic [5:0]  occ;

    memstream_strm_fifo #(
        .WIDTH(32), .DEPTH(D), .AFULL_MARGIN(M), .RAM_STYLE("auto")
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
        .s_axis_afull(s_afull),
        .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
        .occupancy(occ)
    );

    always #5 aclk = ~aclk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        n_checks++;
        if (act !== want) begin
            n_errors++;
            if (n_errors <= 40)
                $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, want, $time);
        end
    endtask

    // Reference model: words in flight with the edge at which each was pushed.
    typedef struct { logic [31:0] d; int e; } ent_t;
    ent_t mq[$];
    int   edge_n = 0;
    bit   exp_tready = 0, exp_afull = 0;
    bit   last_push = 0, last_pop = 0, rst_edge = 0;

    // A word is presentable two edges after its push, once it reaches the head.
    function automatic bit exp_valid();
        return (mq.size() > 0) && (edge_n >= mq[0].e + 2);
    endfunction

    function automatic int exp_occ();
`ifdef MEMSTREAM_STRM_FIFO_OCCUPANCY_EN
        return mq.size();
`else
        return 0;
`endif
    endfunction

    always @(posedge aclk) begin
        bit pv;
        pv = exp_valid();
        edge_n++;
        last_push = 0;
        last_pop  = 0;
        if (!aresetn) begin
            mq.delete();
            exp_tready = 0;
            exp_afull  = 0;
            rst_edge   = 1;
        end else begin
            rst_edge = 0;
            if (pv && m_tready) begin
                void'(mq.pop_front());
                last_pop = 1;
            end
            if (s_tvalid && exp_tready) begin
                ent_t ne;
                ne.d = s_tdata;
                ne.e = edge_n;
                mq.push_back(ne);
                last_push = 1;
            end
            exp_tready = (mq.size() < D);
            exp_afull  = (mq.size() >= D - M);
        end
    end

    always @(negedge aclk) begin
        if (edge_n > 0) begin
            check("tready", s_tready, exp_tready);
            check("afull", s_afull, exp_afull);
            check("tvalid", m_tvalid, exp_valid());
            check("occupancy", occ, exp_occ());
            if (exp_valid())
                check("tdata", m_tdata, mq[0].d);
            else if (rst_edge)
                check("tdata_rst", m_tdata, 0);
        end
    end

    initial begin
        int np, sent, got;
        logic [31:0] nxt;

        repeat (3) @(negedge aclk);
        aresetn = 1'b1;
        check("rst_tvalid", m_tvalid, 0);
        check("rst_tdata", m_tdata, 0);
        check("rst_tready", s_tready, 0);
        check("rst_afull", s_afull, 0);
        check("rst_occ", occ, 0);
        @(negedge aclk);
        check("tready_after_rst", s_tready, 1);

        // Four back-to-back words with a ready consumer.
        m_tready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            s_tvalid = 1'b1;
            s_tdata  = i;
            @(negedge aclk);
            if (i == 2) check("t1_latency", m_tvalid, 0);
            if (i == 3) check("t1_first", m_tdata, 1);
        end
        s_tvalid = 1'b0;
        check("t1_word2", m_tdata, 2);
        @(negedge aclk);
        check("t1_word3", m_tdata, 3);
        @(negedge aclk);
        check("t1_word4", m_tdata, 4);
        @(negedge aclk);
        check("t1_empty", m_tvalid, 0);
        check("t1_occ", occ, 0);

        // Fill with a stalled consumer.
        m_tready = 1'b0;
        s_tvalid = 1'b1;
        s_tdata  = 32'h100;
        np = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge aclk);
            if (last_push) begin
                np++;
                s_tdata++;
                if (np == 27) check("t2_afull_27", s_afull, 0);
                if (np == 28) check("t2_afull_28", s_afull, 1);
                if (np == 31) check("t2_tready_31", s_tready, 1);
                if (np == 32) check("t2_tready_32", s_tready, 0);
            end
        end
        check("t2_pushes", np, 32);
        check("t2_full_tready", s_tready, 0);
        check("t2_full_afull", s_afull, 1);
`ifdef MEMSTREAM_STRM_FIFO_OCCUPANCY_EN
        check("t2_full_occ", occ, 32);
`else
        check("t2_full_occ", occ, 0);
`endif

        // One pop while full: upstream keeps tvalid but must not be accepted that cycle.
        m_tready = 1'b1;
        @(negedge aclk);
        m_tready = 1'b0;
        check("t3_no_push", last_push, 0);
        check("t3_pop", last_pop, 1);
        check("t3_tready", s_tready, 1);
        check("t3_head", m_tdata, 32'h101);
        @(negedge aclk);
        if (last_push) s_tdata++;
        check("t3_refull", s_tready, 0);
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        repeat (40) @(negedge aclk);
        check("t3_drained", m_tvalid, 0);

        // Random valid/ready, incrementing data; the model checks order and stall stability.
        sent = 0;
        got  = 0;
        nxt  = 32'h1000_0000;
        for (int c = 0; c < 60000 && got < 10000; c++) begin
            if (last_push) begin
                sent++;
                nxt++;
            end
            if (last_pop) got++;
            s_tvalid = (sent < 10000) ? 1'($urandom_range(0, 1)) : 1'b0;
            s_tdata  = nxt;
            m_tready = 1'($urandom_range(0, 1));
            @(negedge aclk);
        end
        check("t4_words_out", got, 10000);
        s_tvalid = 1'b0;
        m_tready = 1'b0;
        @(negedge aclk);

        // Reset while holding 10 words, with a handshake attempted in the reset cycle.
        s_tvalid = 1'b1;
        s_tdata  = 32'h500;
        np = 0;
        for (int k = 0; k < 30 && np < 10; k++) begin
            @(negedge aclk);
            if (last_push) begin
                np++;
                s_tdata++;
            end
        end
        check("t5_filled", np, 10);
        aresetn = 1'b0;
        @(negedge aclk);
        aresetn  = 1'b1;
        s_tvalid = 1'b0;
        check("t5_tvalid", m_tvalid, 0);
        check("t5_occ", occ, 0);
        check("t5_afull", s_afull, 0);
        check("t5_tdata", m_tdata, 0);
        @(negedge aclk);
        s_tvalid = 1'b1;
        s_tdata  = 32'hABCD;
        m_tready = 1'b1;
        np = 0;
        for (int k = 0; k < 10 && np == 0; k++) begin
            @(negedge aclk);
            if (last_push) np = 1;
        end
        check("t5_pushed", np, 1);
        s_tvalid = 1'b0;
        repeat (2) @(negedge aclk);
        check("t5_first_valid", m_tvalid, 1);
        check("t5_first_word", m_tdata, 32'hABCD);
        repeat (4) @(negedge aclk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
